// File: rtl/wb_cam_capture_ctrl.sv
// Wishbone-controlled camera frame capture sequencer.
// Arms on a CTRL command, locks to vsync/href timing, writes accepted pixels
// into a single-port frame RAM at raster addresses, and shares that RAM port
// with CPU read-back through RD_ADDR/RD_DATA. Capture writes always win.
module wb_cam_capture_ctrl #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_px_stb,
    input  logic [7:0]        cam_px_dat,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_we,
    output logic [7:0]        ram_dat_o,
    input  logic [7:0]        ram_dat_i,
    output logic              irq
);

    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(H_PIXELS * V_LINES - 1);
    localparam logic [ADDR_W-1:0] H_STEP     = ADDR_W'(H_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic              vsync_q, href_q;
    logic              vsync_rise, vsync_fall, href_fall;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line_cnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              cont_q, irq_en_q, done_q, ovr_q;
    logic              ack_q, rd_pend, rd_valid;
    logic [31:0]       dat_q;
    logic [31:0]       rd_mux;

    logic       wb_req, reg_acc, rd_req_new, rd_want, rd_issue;
    logic [1:0] reg_sel;
    logic       wr_ctrl, wr_status, wr_rdaddr;
    logic       start_cmd, abort_cmd;
    logic       px_in, px_ok, px_drop;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign vsync_fall = ~cam_vsync & vsync_q;
    assign href_fall  = ~cam_href & href_q;

    // A new bus access is accepted only when no ack is showing and no
    // RD_DATA read is still waiting for the RAM port.
    assign wb_ack_o   = ack_q | rd_valid;
    assign wb_req     = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~rd_pend;
    assign reg_sel    = wb_adr_i[3:2];
    assign rd_req_new = wb_req & ~wb_we_i & (reg_sel == 2'd3);
    assign reg_acc    = wb_req & ~rd_req_new;
    assign wr_ctrl    = wb_req & wb_we_i & (reg_sel == 2'd0);
    assign wr_status  = wb_req & wb_we_i & (reg_sel == 2'd1);
    assign wr_rdaddr  = wb_req & wb_we_i & (reg_sel == 2'd2);
    assign start_cmd  = wr_ctrl & wb_dat_i[0];
    assign abort_cmd  = wr_ctrl & wb_dat_i[3];

    assign px_in    = (state == S_CAPTURE) & cam_href & cam_px_stb;
    assign px_ok    = px_in & (col < COL_W'(H_PIXELS)) & (line_cnt < LINE_W'(V_LINES));
    assign px_drop  = px_in & ~px_ok;
    assign wr_addr  = line_base + ADDR_W'(col);

    // The read issue can coincide with the request cycle when no pixel is
    // competing, so an uncontended RD_DATA read acks one cycle after request.
    assign rd_want  = rd_pend | rd_req_new;
    assign rd_issue = rd_want & ~px_ok;

    assign ram_we    = px_ok;
    assign ram_adr   = px_ok ? wr_addr : (rd_issue ? rd_ptr : '0);
    assign ram_dat_o = px_ok ? cam_px_dat : '0;

    assign wb_dat_o = rd_valid ? {24'h0, ram_dat_i} : dat_q;
    assign irq      = done_q & irq_en_q;

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux = {29'h0, irq_en_q, cont_q, 1'b0};
            2'd1:    rd_mux = {16'(line_cnt), 8'h00, 5'h00, ovr_q, done_q, (state != S_IDLE)};
            2'd2:    rd_mux = 32'(rd_ptr);
            default: rd_mux = '0;
        endcase
    end

    // Sequencer next-state logic; ABORT overrides every transition.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start_cmd) state_nx = S_ARMED;
            S_ARMED:   if (vsync_rise) state_nx = S_SYNC;
            S_SYNC:    if (vsync_fall) state_nx = S_CAPTURE;
            S_CAPTURE: if (vsync_rise || (href_fall && line_cnt == LINE_W'(V_LINES - 1)))
                           state_nx = S_DONE;
            S_DONE:    state_nx = cont_q ? S_SYNC : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort_cmd) state_nx = S_IDLE;
    end

    // State register and vsync/href edge-detect copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
        end
    end

    // Raster counters: cleared at frame start and on abort, advanced per
    // accepted pixel and per href falling edge.
    always_ff @(posedge clk) begin
        if (reset || abort_cmd) begin
            col       <= '0;
            line_cnt  <= '0;
            line_base <= '0;
        end else if (state == S_SYNC && vsync_fall) begin
            col       <= '0;
            line_cnt  <= '0;
            line_base <= '0;
        end else if (state == S_CAPTURE) begin
            if (href_fall) begin
                col       <= '0;
                line_base <= line_base + H_STEP;
                if (line_cnt < LINE_W'(V_LINES)) line_cnt <= line_cnt + LINE_W'(1);
            end else if (px_ok) begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Control bits and sticky status flags; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                cont_q   <= wb_dat_i[1];
                irq_en_q <= wb_dat_i[2];
            end
            if (state == S_DONE && !abort_cmd) done_q <= 1'b1;
            else if (wr_status && wb_dat_i[1]) done_q <= 1'b0;
            if (px_drop) ovr_q <= 1'b1;
            else if (wr_status && wb_dat_i[2]) ovr_q <= 1'b0;
        end
    end

    // Read pointer: loaded by RD_ADDR, advanced with wrap on each RD_DATA read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_issue) begin
            rd_ptr <= (rd_ptr == FRAME_LAST) ? '0 : rd_ptr + ADDR_W'(1);
        end else if (wr_rdaddr) begin
            rd_ptr <= wb_dat_i[ADDR_W-1:0];
        end
    end

    // Wishbone acknowledge and data for register accesses and RAM reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            ack_q    <= reg_acc;
            dat_q    <= (reg_acc && !wb_we_i) ? rd_mux : '0;
            rd_valid <= rd_issue;
            rd_pend  <= rd_want & ~rd_issue;
        end
    end

endmodule

// File: tb/tb_wb_cam_capture_ctrl.sv
// Self-checking bench for wb_cam_capture_ctrl with a small 4x2 frame.
module tb_wb_cam_capture_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;

    logic          clk, reset;
    logic          wb_stb_i, wb_cyc_i, wb_we_i;
    logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_ack_o;
    logic          cam_vsync, cam_href, cam_px_stb;
    logic [7:0]    cam_px_dat;
    logic [AW-1:0] ram_adr;
    logic          ram_we;
    logic [7:0]    ram_dat_o, ram_dat_i;
    logic          irq;

    wb_cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_px_stb(cam_px_stb), .cam_px_dat(cam_px_dat),
        .ram_adr(ram_adr), .ram_we(ram_we), .ram_dat_o(ram_dat_o),
        .ram_dat_i(ram_dat_i), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame RAM: single port, one-cycle synchronous read.
    logic [7:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) bram[ram_adr] <= ram_dat_o;
        ram_dat_i <= bram[ram_adr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] exp_mem [0:H*V-1];
    int  m_line, m_col, exp_lines, data_ctr;
    bit  exp_done, exp_ovr, exp_busy;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st_exp();
        logic [31:0] l;
        l = exp_lines;
        return {l[15:0], 8'h00, 5'h00, exp_ovr, exp_done, exp_busy};
    endfunction

    task automatic wb_xfer(input logic [3:0] adr, input bit we, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        bit got;
        got = 0; lat = 0; rd = '0;
        wb_adr_i = {28'h0, adr}; wb_we_i = we; wb_dat_i = wd;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                got = 1; rd = wb_dat_o;
            end else begin
                lat++;
            end
            tick();
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        check("wb_ack_seen", got, 1);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(adr, 1'b1, d, rd, lat);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(adr, 1'b0, 32'h0, rd, lat);
        check(tag, rd, exp);
        check({tag, "_latency"}, lat, 1);
    endtask

    // One pixel strobe; accepted iff inside the stored raster window.
    task automatic px(input logic [7:0] d, input bit ack_low);
        bit acc;
        acc = (m_col < H) && (m_line < V);
        cam_px_stb = 1'b1; cam_px_dat = d;
        @(negedge clk);
        if (ack_low) check("arb_ack_wait", wb_ack_o, 0);
        check("px_we", ram_we, acc);
        if (acc) begin
            check("px_adr", ram_adr, m_line * H + m_col);
            check("px_dat", ram_dat_o, d);
            exp_mem[m_line * H + m_col] = d;
            m_col++;
        end else begin
            exp_ovr = 1;
        end
        tick();
        cam_px_stb = 1'b0;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1; tick(); tick();
        cam_vsync = 1'b0; tick(); tick();
        m_line = 0; m_col = 0;
    endtask

    // Drives one href line; leaves href low in the current cycle.
    task automatic line(input int len, input bit rnd);
        cam_href = 1'b1; tick();
        for (int k = 0; k < len; k++) begin
            if (rnd && $urandom_range(0, 1) == 1) tick();
            if (rnd) px(8'($urandom_range(0, 255)), 0);
            else begin
                px(8'(data_ctr), 0);
                data_ctr++;
            end
        end
        cam_href = 1'b0;
        m_line++; m_col = 0;
    endtask

    // Full frame; negative lengths/base pick random lengths/data.
    task automatic frame(input int nl, input bit endv, input int len0, input int len1, input int base);
        if (base >= 0) data_ctr = base;
        vsync_pulse();
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == 0) ? len0 : len1;
            if (len < 0) len = $urandom_range(0, H + 2);
            line(len, base < 0);
            if (l != nl - 1 || endv) begin tick(); tick(); end
        end
        if (endv) cam_vsync = 1'b1;
        exp_lines = nl; exp_done = 1;
    endtask

    task automatic finish_frame();
        tick(); tick();
        cam_vsync = 1'b0;
        tick(); tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_ack"}, wb_ack_o, 0);
        check({tag, "_dat"}, wb_dat_o, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_adr"}, ram_adr, 0);
        check({tag, "_rdat"}, ram_dat_o, 0);
        check({tag, "_irq"}, irq, 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] saved;
        reset = 1'b1;
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        cam_vsync = 0; cam_href = 0; cam_px_stb = 0; cam_px_dat = '0;
        exp_done = 0; exp_ovr = 0; exp_busy = 0; exp_lines = 0; m_line = 0; m_col = 0; data_ctr = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk_reset_outputs("rst");
        rd_check("status_rst", 4'h4, 32'h0);
        rd_check("ctrl_rst", 4'h0, 32'h0);
        rd_check("rdaddr_rst", 4'h8, 32'h0);

        // Basic frame: 2 lines of 4 pixels 0x10..0x17
        wb_write(4'h0, 32'h1);
        exp_busy = 1;
        rd_check("status_armed", 4'h4, st_exp());
        frame(2, 0, 4, 4, 'h10);
        finish_frame();
        exp_busy = 0;
        rd_check("status_frame1", 4'h4, 32'h0002_0002);

        // Overlong line -> overrun, then W1C
        wb_write(4'h4, 32'h6); exp_done = 0;
        wb_write(4'h0, 32'h1); exp_busy = 1;
        frame(2, 0, 6, 4, 'h20);
        finish_frame();
        exp_busy = 0;
        rd_check("status_ovr", 4'h4, 32'h0002_0006);
        wb_write(4'h4, 32'h4); exp_ovr = 0;
        rd_check("status_ovr_clr", 4'h4, 32'h0002_0002);
        wb_write(4'h4, 32'h2); exp_done = 0;

        // RD_DATA contending with back-to-back pixels
        wb_write(4'h8, 32'h5);
        rd_check("rdaddr_load", 4'h8, 32'h5);
        saved = exp_mem[5];
        wb_write(4'h0, 32'h1); exp_busy = 1;
        vsync_pulse();
        cam_href = 1'b1; tick();
        wb_adr_i = 32'hC; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 3; i++) px(8'(8'h40 + i), 1);
        @(negedge clk);
        check("arb_ack_idle", wb_ack_o, 0);
        check("arb_ram_we", ram_we, 0);
        check("arb_ram_adr", ram_adr, 5);
        tick();
        @(negedge clk);
        check("arb_ack", wb_ack_o, 1);
        check("arb_data", wb_dat_o, {24'h0, saved});
        tick();
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        px(8'h43, 0);
        cam_href = 1'b0; m_line++; m_col = 0;
        tick(); tick();
        data_ctr = 'h44;
        line(4, 0);
        exp_lines = 2; exp_done = 1;
        finish_frame();
        exp_busy = 0;
        rd_check("status_arb", 4'h4, st_exp());
        rd_check("rdaddr_inc", 4'h8, 32'h6);

        // Randomized single-shot frames
        for (int f = 0; f < 8; f++) begin
            bit endv;
            int nl;
            wb_write(4'h4, 32'h6); exp_done = 0; exp_ovr = 0;
            wb_write(4'h0, 32'h1); exp_busy = 1;
            endv = 1'($urandom_range(0, 1));
            nl = endv ? $urandom_range(0, V - 1) : V;
            frame(nl, endv, -1, -1, -1);
            finish_frame();
            exp_busy = 0;
            rd_check("status_rand", 4'h4, st_exp());
            check("irq_rand", irq, 0);
        end

        // Full read-back with wrap
        wb_write(4'h8, 32'h0);
        for (int a = 0; a < H * V; a++) rd_check("mem_rd", 4'hC, {24'h0, exp_mem[a]});
        rd_check("ptr_wrap", 4'h8, 32'h0);

        // Continuous capture with interrupts
        wb_write(4'h4, 32'h6); exp_done = 0; exp_ovr = 0;
        wb_write(4'h0, 32'h7); exp_busy = 1;
        frame(V, 0, -1, -1, -1);
        @(negedge clk); check("irq_t0", irq, 0); tick();
        @(negedge clk); check("irq_t1", irq, 0); tick();
        @(negedge clk); check("irq_t2", irq, 1); tick();
        tick();
        rd_check("status_cont_a", 4'h4, st_exp());
        rd_check("ctrl_cont", 4'h0, 32'h6);
        wb_write(4'h4, 32'h2); exp_done = 0;
        @(negedge clk); check("irq_clr", irq, 0); tick();
        frame(V, 0, -1, -1, -1);
        finish_frame();
        rd_check("status_cont_b", 4'h4, st_exp());
        check("irq_cont_b", irq, 1);

        // Abort mid-frame
        wb_write(4'h4, 32'h2); exp_done = 0;
        vsync_pulse();
        cam_href = 1'b1; tick();
        data_ctr = 'h70;
        px(8'h70, 0);
        px(8'h71, 0);
        wb_write(4'h0, 32'h8);
        exp_busy = 0; exp_lines = 0;
        rd_check("status_abort", 4'h4, st_exp());
        rd_check("ctrl_abort", 4'h0, 32'h0);
        check("irq_abort", irq, 0);
        cam_href = 1'b0; tick(); tick();

        // Reset asserted during capture
        wb_write(4'h4, 32'h6); exp_ovr = 0;
        wb_write(4'h0, 32'h1); exp_busy = 1;
        vsync_pulse();
        cam_href = 1'b1; tick();
        px(8'h50, 0);
        px(8'h51, 0);
        reset = 1'b1; tick();
        reset = 1'b0;
        cam_px_stb = 1'b1; cam_px_dat = 8'hAA;
        chk_reset_outputs("rst_cap");
        cam_px_stb = 1'b0; cam_href = 1'b0; tick();
        exp_done = 0; exp_ovr = 0; exp_busy = 0; exp_lines = 0;
        rd_check("status_rst_cap", 4'h4, 32'h0);
        rd_check("rdaddr_rst_cap", 4'h8, 32'h0);
        wb_write(4'h0, 32'h1); exp_busy = 1;
        frame(2, 0, 4, 4, 'h60);
        finish_frame();
        exp_busy = 0;
        rd_check("status_after_rst", 4'h4, 32'h0002_0002);
        for (int a = 0; a < H * V; a++) rd_check("mem_rd2", 4'hC, {24'h0, exp_mem[a]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
